lane_game_engine: RTL

//  Frame-rate game core for the lane-dodging VGA game: owns the game FSM, N falling-obstacle

---
 rtl/lane_game_pkg.sv | 16 +
 rtl/lane_game_if.sv | 30 +++
 rtl/lane_obstacle.sv | 40 ++++
 rtl/lane_game_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lane_game_pkg.sv
// rtl/lane_game_pkg.sv - shared state encoding and widths for the lane game core
package lane_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } state_t;

    localparam logic [2:0] MUSIC_SILENT = 3'd4;
    localparam int         POS_W        = 10;
    localparam int         SCORE_W      = 11;

endpackage

// File: rtl/lane_game_if.sv
// rtl/lane_game_if.sv - frame/pixel inputs and display/score outputs of the game core
interface lane_game_if
    import lane_game_pkg::*;
#(
    parameter int N_OBST = 5
) ();

    logic                      frame_tick;
    logic                      start;
    logic                      pix_en;
    logic                      player_px;
    logic [N_OBST-1:0]         obst_px;
    logic [POS_W*N_OBST-1:0]   obst_v;
    logic [N_OBST-1:0]         obst_active;
    logic [2:0]                state;
    logic [SCORE_W-1:0]        score;
    logic [1:0]                level;
    logic [2:0]                music_sel;

    modport master (
        output frame_tick, start, pix_en, player_px, obst_px,
        input  obst_v, obst_active, state, score, level, music_sel
    );

    modport slave (
        input  frame_tick, start, pix_en, player_px, obst_px,
        output obst_v, obst_active, state, score, level, music_sel
    );

endinterface

// File: rtl/lane_obstacle.sv
// rtl/lane_obstacle.sv - one falling obstacle: release compare, position register, wrap
module lane_obstacle
    import lane_game_pkg::*;
#(
    parameter int IDX       = 0,
    parameter int SPAWN_GAP = 20,
    parameter int V_MAX     = 480,
    parameter int SPAWN_W   = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               tick,
    input  logic               clear,
    input  logic [2:0]         speed,
    input  logic [SPAWN_W-1:0] spawn,
    output logic [POS_W-1:0]   v,
    output logic               active
);

    localparam logic [SPAWN_W-1:0] RELEASE_AT = SPAWN_W'(IDX * SPAWN_GAP);
    localparam logic [POS_W:0]     WRAP_AT    = (POS_W + 1)'(V_MAX);

    logic [POS_W:0] v_next;

    assign v_next = {1'b0, v} + {{(POS_W - 2){1'b0}}, speed};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            v      <= '0;
            active <= 1'b0;
        end else begin
            if (run && spawn == RELEASE_AT)
                active <= 1'b1;
            if (tick && active)
                v <= (v_next >= WRAP_AT) ? '0 : v_next[POS_W-1:0];
        end
    end

endmodule

// File: rtl/lane_game_engine.sv
// rtl/lane_game_engine.sv - frame-rate game core: FSM, collision latch, score/level, obstacles
module lane_game_engine
    import lane_game_pkg::*;
#(
    parameter int N_OBST     = 5,
    parameter int V_MAX      = 480,
    parameter int SCORE_MAX  = 600,
    parameter int LEVEL_STEP = 150,
    parameter int N_LEVELS   = 4,
    parameter int SCORE_DIV  = 4,
    parameter int SPAWN_GAP  = 20
) (
    input logic        clock,
    input logic        reset,
    lane_game_if.slave bus
);

    localparam int SPAWN_LAST = (N_OBST - 1) * SPAWN_GAP;
    localparam int SPAWN_W    = $clog2(SPAWN_LAST + 2);
    localparam int STEP_W     = $clog2(LEVEL_STEP + 1);
    localparam int DIV_W      = $clog2(SCORE_DIV + 1);

    localparam logic [SPAWN_W-1:0] SPAWN_END  = SPAWN_W'(SPAWN_LAST);
    localparam logic [STEP_W-1:0]  STEP_END   = STEP_W'(LEVEL_STEP - 1);
    localparam logic [DIV_W-1:0]   DIV_END    = DIV_W'(SCORE_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_END  = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(SCORE_MAX - 1);
    localparam logic [1:0]         LEVEL_END  = 2'(N_LEVELS - 1);

    state_t               state;
    logic                 start_q;
    logic                 hit_latch;
    logic [SCORE_W-1:0]   score;
    logic [1:0]           level;
    logic [2:0]           music_sel;
    logic [STEP_W-1:0]    step_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [SPAWN_W-1:0]   spawn_cnt;
    logic [N_OBST-1:0]    active;

    logic start_rise, hit, collide, run_st, tick_run, frame_go, score_inc, win_now, obst_clear;
    logic [1:0] level_nxt;
    logic [2:0] speed;

    always_comb begin
        start_rise = bus.start & ~start_q;
        hit        = bus.pix_en & bus.player_px & (|(bus.obst_px & active));
        collide    = hit_latch | hit;
        run_st     = (state == ST_RUN);
        tick_run   = run_st & bus.frame_tick;
        frame_go   = tick_run & ~collide;
        score_inc  = frame_go & (div_cnt == DIV_END) & (score != SCORE_END);
        win_now    = score_inc & (score == SCORE_LAST);
        obst_clear = (state == ST_IDLE) & start_rise;
        speed      = {1'b0, level} + 3'd1;
        level_nxt  = level;
        if (score_inc && step_cnt == STEP_END && level != LEVEL_END)
            level_nxt = level + 2'd1;
    end

    // A colliding frame freezes movement and scoring; only the transition to OVER happens.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            hit_latch <= 1'b0;
            score     <= '0;
            level     <= '0;
            step_cnt  <= '0;
            div_cnt   <= '0;
            spawn_cnt <= '0;
            music_sel <= MUSIC_SILENT;
        end else begin
            start_q <= bus.start;
            if (frame_go) begin
                div_cnt <= (div_cnt == DIV_END) ? '0 : div_cnt + DIV_W'(1);
                if (score_inc) begin
                    score    <= score + SCORE_W'(1);
                    step_cnt <= (step_cnt == STEP_END) ? '0 : step_cnt + STEP_W'(1);
                end
                level <= level_nxt;
                if (spawn_cnt != SPAWN_END)
                    spawn_cnt <= spawn_cnt + SPAWN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    hit_latch <= 1'b0;
                    if (start_rise) begin
                        state     <= ST_RUN;
                        score     <= '0;
                        level     <= '0;
                        step_cnt  <= '0;
                        div_cnt   <= '0;
                        spawn_cnt <= '0;
                        music_sel <= 3'd0;
                    end
                end
                ST_RUN: begin
                    hit_latch <= (bus.frame_tick | start_rise) ? 1'b0 : collide;
                    if (tick_run && collide) begin
                        state     <= ST_OVER;
                        music_sel <= MUSIC_SILENT;
                    end else if (win_now) begin
                        state     <= ST_WIN;
                        music_sel <= MUSIC_SILENT;
                    end else if (start_rise) begin
                        state     <= ST_PAUSE;
                        music_sel <= MUSIC_SILENT;
                    end else begin
                        music_sel <= {1'b0, level_nxt};
                    end
                end
                ST_PAUSE: begin
                    hit_latch <= 1'b0;
                    if (start_rise) begin
                        state     <= ST_RUN;
                        music_sel <= {1'b0, level};
                    end
                end
                ST_OVER, ST_WIN: begin
                    hit_latch <= 1'b0;
                    if (start_rise)
                        state <= ST_IDLE;
                end
                default: begin
                    hit_latch <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_OBST; i++) begin : g_obst
        lane_obstacle #(
            .IDX      (i),
            .SPAWN_GAP(SPAWN_GAP),
            .V_MAX    (V_MAX),
            .SPAWN_W  (SPAWN_W)
        ) u_obst (
            .clock (clock),
            .reset (reset),
            .run   (run_st),
            .tick  (frame_go),
            .clear (obst_clear),
            .speed (speed),
            .spawn (spawn_cnt),
            .v     (bus.obst_v[POS_W*i +: POS_W]),
            .active(active[i])
        );
    end

    assign bus.obst_active = active;
    assign bus.state       = state;
    assign bus.score       = score;
    assign bus.level       = level;
    assign bus.music_sel   = music_sel;

endmodule
